// File: rtl/h264_recon_pkg.sv
// Shared types and constants for the intra 8x8 reconstruction slice.
// Latency: n/a (types, constants and a combinational clip helper only).
// Backpressure: n/a.
package h264_recon_pkg;

  localparam int FIFO_DEPTH    = 16;
  localparam int FIFO_AW       = 4;
  localparam int PIX_W         = 8;
  localparam int RES_W         = 9;
  localparam int LANES         = 4;
  localparam int WORDS_PER_BLK = 16;

  // Pixel/lane 0 sits in the least significant bits of each word.
  typedef logic [LANES-1:0][PIX_W-1:0] pix_word_t;
  typedef logic [LANES-1:0][RES_W-1:0] res_word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } recon_state_t;

  // Unsigned base + signed residual. The sum spans -256..510, so 11 bits
  // hold it without loss; bit 10 is the sign and bits 9:8 flag > 255.
  function automatic logic [PIX_W-1:0] clip_lane(input logic [PIX_W-1:0] base,
                                                 input logic [RES_W-1:0] res);
    logic [10:0] sum;
    sum = {3'b000, base} + {{2{res[RES_W-1]}}, res};
    if (sum[10])
      return 8'h00;
    else if (sum[9:8] != 2'b00)
      return 8'hFF;
    else
      return sum[7:0];
  endfunction

endpackage

// File: rtl/intra8x8_base_fifo.sv
// Base-word FIFO, 16 x 32, holding predictor words until their residual arrives.
// Latency: fall-through read (dout is the head word combinationally); push visible next cycle.
// Backpressure: none upstream; a push while full without a same-cycle pop is dropped and flagged.
// Ports: CLK2/rst clock and sync reset; push/din write side; pop/dout read side;
//        full/empty status; overflow is a one-cycle indication of a dropped push.
module intra8x8_base_fifo
  import h264_recon_pkg::*;
(
  input  logic        CLK2,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty,
  output logic        overflow
);

  logic [31:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign full     = (cnt == (FIFO_AW+1)'(FIFO_DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop & ~empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign dout     = mem[rptr];

  always_ff @(posedge CLK2) begin
    if (do_push)
      mem[wptr] <= din;
  end

  always_ff @(posedge CLK2) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push)
        wptr <= wptr + 1'b1;
      if (do_pop)
        rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/intra8x8_recon.sv
// Intra 8x8 reconstruction: adds residual words to queued base words, clips, serialises pixels.
// Latency: pixel 0 one cycle after the accepting edge; 4 pixels per word, back-to-back when fed.
// Backpressure: READYI low during pixels 0..2 of a word; residual strobes then are ignored.
// Ports: CLK2, RST, NEWSLICE (flush); BASEI/BSTROBEI base push, BFULL; RESI/RSTROBEI/READYI
//        residual handshake; FEEDBO/FBSTROBE pixel stream; TOPO/TOPSTROBE row-7 words;
//        BLKDONE end of block; ERR sticky {underflow, overflow}.
module intra8x8_recon
  import h264_recon_pkg::*;
(
  input  logic        CLK2,
  input  logic        RST,
  input  logic        NEWSLICE,
  input  logic [31:0] BASEI,
  input  logic        BSTROBEI,
  input  logic [35:0] RESI,
  input  logic        RSTROBEI,
  output logic        READYI,
  output logic        BFULL,
  output logic [7:0]  FEEDBO,
  output logic        FBSTROBE,
  output logic [31:0] TOPO,
  output logic        TOPSTROBE,
  output logic        BLKDONE,
  output logic [1:0]  ERR
);

  recon_state_t state;
  logic [1:0]   bidx;
  pix_word_t    shreg;
  logic [3:0]   wcnt;
  logic         lastword;   // word being emitted is word 15 of the block

  logic         clr;
  logic         accept;
  logic         take;
  logic         underflow;
  logic         fifo_empty;
  logic         fifo_ovf;
  logic [31:0]  fifo_dout;
  pix_word_t    base_w;
  res_word_t    res_w;
  pix_word_t    clipped;

  assign clr = RST | NEWSLICE;

  intra8x8_base_fifo u_fifo (
    .CLK2     (CLK2),
    .rst      (clr),
    .push     (BSTROBEI),
    .din      (BASEI),
    .pop      (take),
    .dout     (fifo_dout),
    .full     (BFULL),
    .empty    (fifo_empty),
    .overflow (fifo_ovf)
  );

  assign READYI    = (state == ST_IDLE) | (bidx == 2'd3);
  assign accept    = RSTROBEI & READYI;
  // Empty-FIFO check uses current occupancy: a same-cycle push is not yet visible.
  assign take      = accept & ~fifo_empty;
  assign underflow = accept & fifo_empty;

  assign base_w = pix_word_t'(fifo_dout);
  assign res_w  = res_word_t'(RESI);

  always_comb begin
    clipped = '0;
    for (int i = 0; i < LANES; i++)
      clipped[i] = clip_lane(base_w[i], res_w[i]);
  end

  always_ff @(posedge CLK2) begin
    if (clr) begin
      state     <= ST_IDLE;
      bidx      <= 2'd0;
      shreg     <= '0;
      wcnt      <= 4'd0;
      lastword  <= 1'b0;
      FEEDBO    <= 8'h00;
      FBSTROBE  <= 1'b0;
      TOPO      <= 32'h0;
      TOPSTROBE <= 1'b0;
      BLKDONE   <= 1'b0;
      ERR       <= 2'b00;
    end else begin
      ERR       <= ERR | {underflow, fifo_ovf};
      TOPSTROBE <= 1'b0;
      BLKDONE   <= 1'b0;
      if (take) begin
        state    <= ST_EMIT;
        bidx     <= 2'd0;
        shreg    <= clipped;
        FEEDBO   <= clipped[0];
        FBSTROBE <= 1'b1;
        wcnt     <= wcnt + 4'd1;
        lastword <= (wcnt == 4'd15);
        // Words 14 and 15 form the bottom row of the 8x8 block.
        if (wcnt[3:1] == 3'b111) begin
          TOPO      <= clipped;
          TOPSTROBE <= 1'b1;
        end
      end else if ((state == ST_EMIT) && (bidx != 2'd3)) begin
        bidx     <= bidx + 2'd1;
        FEEDBO   <= shreg[bidx + 2'd1];
        FBSTROBE <= 1'b1;
        BLKDONE  <= lastword & (bidx == 2'd2);
      end else begin
        state    <= ST_IDLE;
        bidx     <= 2'd0;
        FEEDBO   <= 8'h00;
        FBSTROBE <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_intra8x8_recon.sv
// Directed bench for intra8x8_recon with hand-computed expectations.
// Latency: n/a. Backpressure: drives residuals held until READYI accepts them.
module tb_intra8x8_recon;

  logic        CLK2;
  logic        RST;
  logic        NEWSLICE;
  logic [31:0] BASEI;
  logic        BSTROBEI;
  logic [35:0] RESI;
  logic        RSTROBEI;
  logic        READYI;
  logic        BFULL;
  logic [7:0]  FEEDBO;
  logic        FBSTROBE;
  logic [31:0] TOPO;
  logic        TOPSTROBE;
  logic        BLKDONE;
  logic [1:0]  ERR;

  int tests = 0;
  int fails = 0;

  intra8x8_recon dut (
    .CLK2      (CLK2),
    .RST       (RST),
    .NEWSLICE  (NEWSLICE),
    .BASEI     (BASEI),
    .BSTROBEI  (BSTROBEI),
    .RESI      (RESI),
    .RSTROBEI  (RSTROBEI),
    .READYI    (READYI),
    .BFULL     (BFULL),
    .FEEDBO    (FEEDBO),
    .FBSTROBE  (FBSTROBE),
    .TOPO      (TOPO),
    .TOPSTROBE (TOPSTROBE),
    .BLKDONE   (BLKDONE),
    .ERR       (ERR)
  );

  initial CLK2 = 1'b0;
  always #5 CLK2 = ~CLK2;

  task automatic step();
    @(posedge CLK2);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [35:0] mkres(input int l0, input int l1, input int l2, input int l3);
    return {9'(l3), 9'(l2), 9'(l1), 9'(l0)};
  endfunction

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  // Push one base, send one residual, check the four serial pixels.
  task automatic word_test(input string tag, input logic [31:0] base,
                           input logic [35:0] res, input logic [31:0] exp);
    BASEI = base; BSTROBEI = 1'b1;
    step();
    BSTROBEI = 1'b0;
    RESI = res; RSTROBEI = 1'b1;
    step();
    RSTROBEI = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk({tag, "_strobe"}, 32'(FBSTROBE), 32'd1);
      chk({tag, "_pix"}, 32'(FEEDBO), 32'(exp[8*k +: 8]));
      step();
    end
    chk({tag, "_idle"}, 32'(FBSTROBE), 32'd0);
  endtask

  initial begin
    int acc;
    int n;
    int nblk;
    int blk_at;
    int ntop;
    int first_s;
    int last_s;

    RST = 1'b1; NEWSLICE = 1'b0;
    BASEI = 32'h12345678; BSTROBEI = 1'b1;   // discarded: reset has priority
    RESI = '0; RSTROBEI = 1'b1;
    step();
    step();
    BSTROBEI = 1'b0; RSTROBEI = 1'b0;
    chk("rst_fifo_cnt", 32'(dut.u_fifo.cnt), 32'd0);
    chk("rst_feedbo",   32'(FEEDBO),    32'd0);
    chk("rst_fbstrobe", 32'(FBSTROBE),  32'd0);
    chk("rst_topo",     TOPO,           32'd0);
    chk("rst_topstrobe",32'(TOPSTROBE), 32'd0);
    chk("rst_blkdone",  32'(BLKDONE),   32'd0);
    chk("rst_err",      32'(ERR),       32'd0);
    chk("rst_bfull",    32'(BFULL),     32'd0);
    chk("rst_readyi",   32'(READYI),    32'd1);
    RST = 1'b0;

    // 128+5, 128-3, 128+0, 128+127 -> 85,7D,80,FF
    word_test("basic", 32'h80808080, mkres(5, -3, 0, 127), 32'hFF807D85);
    // Pixel 0 is the low byte F0: F0-20=DC, 10+40=38, FF-256<0, 00+255=FF
    word_test("clip_a", 32'h00FF10F0, mkres(-20, 40, -256, 255), 32'hFF0038DC);
    // Pixels 00,FF,10,F0 -> all four lanes clip: 00,FF,00,FF
    word_test("clip_b", 32'hF010FF00, mkres(-20, 40, -256, 255), 32'hFF00FF00);
    chk("word_err", 32'(ERR), 32'd0);

    // Full block: pixels of word w are 4w..4w+3, zero residual, so stream index == pixel value.
    do_reset();
    for (int w = 0; w < 16; w++) begin
      BASEI = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      BSTROBEI = 1'b1;
      step();
    end
    BSTROBEI = 1'b0;
    chk("blk_bfull", 32'(BFULL), 32'd1);
    RESI = '0; RSTROBEI = 1'b1;
    acc = 0; n = 0; nblk = 0; blk_at = -1; ntop = 0; first_s = -1; last_s = -1;
    for (int c = 0; c < 90; c++) begin
      if (RSTROBEI && READYI) acc++;
      step();
      if (acc == 16) RSTROBEI = 1'b0;
      if (FBSTROBE) begin
        if (first_s < 0) first_s = c;
        last_s = c;
        chk("blk_pix", 32'(FEEDBO), 32'(n));
        if (TOPSTROBE) begin
          ntop++;
          chk("blk_top_at", 32'(n), (ntop == 1) ? 32'd56 : 32'd60);
          chk("blk_topo", TOPO, (ntop == 1) ? 32'h3B3A3938 : 32'h3F3E3D3C);
        end
        if (BLKDONE) begin
          nblk++;
          blk_at = n;
        end
        n++;
      end
    end
    chk("blk_count", 32'(n), 32'd64);
    chk("blk_contig", 32'(last_s - first_s + 1), 32'd64);
    chk("blk_ntop", 32'(ntop), 32'd2);
    chk("blk_nblkdone", 32'(nblk), 32'd1);
    chk("blk_blkdone_at", 32'(blk_at), 32'd63);
    chk("blk_err", 32'(ERR), 32'd0);

    // Residual into an empty FIFO.
    do_reset();
    RSTROBEI = 1'b1;
    step();
    RSTROBEI = 1'b0;
    chk("uf_err", 32'(ERR), 32'd2);
    chk("uf_strobe", 32'(FBSTROBE), 32'd0);
    step();
    chk("uf_strobe2", 32'(FBSTROBE), 32'd0);

    // 16 pushes fill without error; the 17th overflows.
    BASEI = 32'h01020304; BSTROBEI = 1'b1;
    for (int i = 0; i < 16; i++) step();
    chk("ovf_err16", 32'(ERR), 32'd2);
    chk("ovf_bfull16", 32'(BFULL), 32'd1);
    step();
    BSTROBEI = 1'b0;
    chk("ovf_err17", 32'(ERR), 32'd3);
    chk("ovf_bfull17", 32'(BFULL), 32'd1);
    chk("ovf_cnt17", 32'(dut.u_fifo.cnt), 32'd16);

    // Push and pop together while full: succeeds, no error.
    do_reset();
    BSTROBEI = 1'b1;
    for (int i = 0; i < 16; i++) step();
    RSTROBEI = 1'b1;
    step();
    BSTROBEI = 1'b0; RSTROBEI = 1'b0;
    chk("pp_err", 32'(ERR), 32'd0);
    chk("pp_cnt", 32'(dut.u_fifo.cnt), 32'd16);
    chk("pp_strobe", 32'(FBSTROBE), 32'd1);

    // Push and residual together into an empty FIFO: still an underflow.
    do_reset();
    BASEI = 32'h55555555; BSTROBEI = 1'b1; RSTROBEI = 1'b1;
    step();
    BSTROBEI = 1'b0; RSTROBEI = 1'b0;
    chk("sim_err", 32'(ERR), 32'd2);
    chk("sim_cnt", 32'(dut.u_fifo.cnt), 32'd1);
    chk("sim_strobe", 32'(FBSTROBE), 32'd0);

    // NEWSLICE mid-word aborts output and clears state.
    do_reset();
    RSTROBEI = 1'b1;
    step();
    RSTROBEI = 1'b0;
    BASEI = 32'h80808080; BSTROBEI = 1'b1;
    step();
    step();
    BSTROBEI = 1'b0;
    RESI = mkres(1, 2, 3, 4); RSTROBEI = 1'b1;
    step();
    RSTROBEI = 1'b0;
    step();
    chk("ns_pix1", 32'(FEEDBO), 32'h82);
    chk("ns_err_pre", 32'(ERR), 32'd2);
    NEWSLICE = 1'b1;
    step();
    NEWSLICE = 1'b0;
    chk("ns_strobe", 32'(FBSTROBE), 32'd0);
    chk("ns_cnt", 32'(dut.u_fifo.cnt), 32'd0);
    chk("ns_err", 32'(ERR), 32'd0);
    chk("ns_readyi", 32'(READYI), 32'd1);
    step();
    chk("ns_strobe2", 32'(FBSTROBE), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
